// File: rtl/cpu_pkg.sv
// Shared types and constants for the execute-issue stage.
// Holds the ALU opcode enum, the per-instruction issue entry and the operand
// resolve helper used ahead of the skid buffer.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 3;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100
  } alu_op_t;

  typedef struct packed {
    logic [XLEN-1:0]       operand_a;
    logic [XLEN-1:0]       operand_b;
    logic [CTRL_W-1:0]     alu_ctrl;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_write;
  } issue_entry_t;

  // x0 always reads zero; EX forwarding wins over WB, which wins over the register file.
  function automatic logic [XLEN-1:0] resolve_src(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [XLEN-1:0]       rf_data,
    input logic                  ex_valid,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic [XLEN-1:0]       ex_data,
    input logic                  wb_valid,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [XLEN-1:0]       wb_data
  );
    logic [XLEN-1:0] src;
    if (addr == '0) begin
      src = '0;
    end else if (ex_valid && (ex_rd == addr)) begin
      src = ex_data;
    end else if (wb_valid && (wb_rd == addr)) begin
      src = wb_data;
    end else begin
      src = rf_data;
    end
    return src;
  endfunction

endpackage

// File: rtl/issue_skid_buffer.sv
// Two-entry valid/ready buffer of issue entries with flush.
// The main entry drives the outputs; the skid entry absorbs one extra
// instruction so in_ready can come straight from a flop.
module issue_skid_buffer
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  issue_entry_t in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output issue_entry_t out_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         in_ready_q, in_ready_d;
  issue_entry_t main_q, main_d;
  issue_entry_t skid_q, skid_d;
  logic         in_fire;
  logic         out_fire;

  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = main_valid_q && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

  // Next-state for both entries: flush empties everything, otherwise keep strict FIFO order.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (main_valid_q) begin
        skid_d       = in_data;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = in_data;
        main_valid_d = 1'b1;
      end
    end
    in_ready_d = !(main_valid_d && skid_valid_d);
  end

  // Entry storage; reset clears data too so the ALU sees zeros straight away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue stage ahead of the ALU.
// Resolves operands once at capture (forwarding and immediate select), then
// queues the result in a two-entry skid buffer and counts output stall cycles.
module alu_issue_stage
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_use_imm,
  input  logic [CTRL_W-1:0]     in_alu_ctrl,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_reg_write,
  input  logic                  ex_fwd_valid,
  input  logic [REG_ADDR_W-1:0] ex_fwd_rd,
  input  logic [XLEN-1:0]       ex_fwd_data,
  input  logic                  wb_fwd_valid,
  input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]       wb_fwd_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       operand_a,
  output logic [XLEN-1:0]       operand_b,
  output logic [CTRL_W-1:0]     alu_control,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_reg_write,
  output logic [31:0]           stall_count
);

  issue_entry_t in_entry;
  issue_entry_t out_entry;
  logic [31:0]  stall_count_q, stall_count_d;

  // Build the entry from the decode inputs; held entries are never re-resolved.
  always_comb begin
    in_entry.operand_a = resolve_src(in_rs1_addr, in_rs1_data, ex_fwd_valid, ex_fwd_rd,
                                     ex_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
    in_entry.operand_b = in_use_imm ? in_imm
                       : resolve_src(in_rs2_addr, in_rs2_data, ex_fwd_valid, ex_fwd_rd,
                                     ex_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
    in_entry.alu_ctrl  = in_alu_ctrl;
    in_entry.rd_addr   = in_rd_addr;
    in_entry.reg_write = in_reg_write;
  end

  issue_skid_buffer u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry)
  );

  assign operand_a     = out_entry.operand_a;
  assign operand_b     = out_entry.operand_b;
  assign alu_control   = out_entry.alu_ctrl;
  assign out_rd_addr   = out_entry.rd_addr;
  assign out_reg_write = out_entry.reg_write;
  assign stall_count   = stall_count_q;

  // Saturating count of cycles where the ALU holds back a valid instruction.
  always_comb begin
    stall_count_d = stall_count_q;
    if (out_valid && !out_ready && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

endmodule
